// File: rtl/cv32e40p_prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_prefetch_pkg
// Purpose  : Shared types for the parametrised instruction prefetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
package cv32e40p_prefetch_pkg;

  // Width of the default instruction word carried by fetch_entry_t
  localparam int unsigned PF_DATA_W = 32;

  // One buffered fetch result: instruction word plus its bus-error flag
  typedef struct packed {
    logic [PF_DATA_W-1:0] data;
    logic                 err;
  } fetch_entry_t;

  // Request-side state of the OBI fetch port
  typedef enum logic [1:0] {
    IDLE             = 2'd0,
    WAIT_GNT         = 2'd1,
    WAIT_GNT_FLUSHED = 2'd2
  } pf_state_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_prefetch_fifo
// Purpose  : Synchronous FIFO with flush, occupancy count and empty/full.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q;
  logic [PTR_W-1:0] wptr_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointers and count; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PTR_W'(1);
      if (pop_i)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage is data-only and needs no reset; reads are qualified by empty
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_prefetch_buffer_n.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_prefetch_buffer_n
// Purpose  : Instruction prefetcher with configurable FIFO depth and number
//            of outstanding OBI requests; flushes on branch / hwloop jump.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40p_prefetch_buffer_n
  import cv32e40p_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_i,
  input  logic                       branch_i,
  input  logic [ADDR_W-1:0]          branch_addr_i,
  input  logic                       hwlp_jump_i,
  input  logic [ADDR_W-1:0]          hwlp_target_i,
  input  logic                       fetch_ready_i,
  output logic                       fetch_valid_o,
  output logic [DATA_W-1:0]          fetch_rdata_o,
  output logic                       fetch_err_o,
  output logic                       instr_req_o,
  input  logic                       instr_gnt_i,
  output logic [ADDR_W-1:0]          instr_addr_o,
  input  logic [DATA_W-1:0]          instr_rdata_i,
  input  logic                       instr_rvalid_i,
  input  logic                       instr_err_i,
  output logic [$clog2(DEPTH+1)-1:0] fifo_cnt_o,
  output logic                       busy_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = DATA_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [CNT_W-1:0]  MAX_OUT_C  = CNT_W'(MAX_OUT);
  localparam logic [SUM_W-1:0]  DEPTH_C    = SUM_W'(DEPTH);

  pf_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [CNT_W-1:0]  out_cnt_d;
  logic [CNT_W-1:0]  discard_cnt_q;
  logic [CNT_W-1:0]  discard_cnt_d;
  logic [CNT_W-1:0]  fifo_cnt_d;

  logic              w_flush;
  logic [ADDR_W-1:0] w_target;
  logic              w_gnt;
  logic              w_drop;
  logic              w_keep;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_can_issue;
  logic              w_late_junk;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [ENT_W-1:0]  w_fifo_head;

  // Branch wins over a simultaneous hardware-loop jump
  assign w_flush  = branch_i | hwlp_jump_i;
  assign w_target = (branch_i ? branch_addr_i : hwlp_target_i) & ALIGN_MASK;

  assign w_gnt    = instr_req_o & instr_gnt_i;
  assign w_drop   = instr_rvalid_i & (discard_cnt_q != '0);
  assign w_keep   = instr_rvalid_i & ~w_drop;
  assign w_bypass = w_keep & w_fifo_empty & fetch_ready_i & ~w_flush;
  assign w_push   = w_keep & ~w_bypass & ~w_flush;
  assign w_pop    = ~w_fifo_empty & fetch_ready_i & ~w_flush;

  assign out_cnt_d  = out_cnt_q + CNT_W'(w_gnt) - CNT_W'(instr_rvalid_i);
  assign fifo_cnt_d = w_flush ? '0 : (w_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop));

  // Every outstanding request reserves a FIFO slot, so pushes never overflow
  assign w_can_issue = (out_cnt_d < MAX_OUT_C) &&
                       (({1'b0, fifo_cnt_d} + {1'b0, out_cnt_d}) < DEPTH_C);

  // The request held across a flush is granted later and must be discarded too
  assign w_late_junk   = (state_q == WAIT_GNT_FLUSHED) & w_gnt;
  assign discard_cnt_d = w_flush ? out_cnt_d
                                 : (discard_cnt_q - CNT_W'(w_drop) + CNT_W'(w_late_junk));

  // Request FSM, fetch address and outstanding/discard bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      pend_addr_q   <= '0;
      out_cnt_q     <= '0;
      discard_cnt_q <= '0;
    end else begin
      out_cnt_q     <= out_cnt_d;
      discard_cnt_q <= discard_cnt_d;
      case (state_q)
        IDLE: begin
          if (w_flush) addr_q <= w_target;
          if (req_i && w_can_issue) state_q <= WAIT_GNT;
        end
        WAIT_GNT: begin
          if (w_gnt) begin
            addr_q  <= w_flush ? w_target : (addr_q + ADDR_W'(4));
            state_q <= (req_i && w_can_issue) ? WAIT_GNT : IDLE;
          end else if (w_flush) begin
            // OBI forbids changing an ungranted request: park the new target
            pend_addr_q <= w_target;
            state_q     <= WAIT_GNT_FLUSHED;
          end
        end
        WAIT_GNT_FLUSHED: begin
          if (w_gnt) begin
            addr_q  <= w_flush ? w_target : pend_addr_q;
            state_q <= (req_i && w_can_issue) ? WAIT_GNT : IDLE;
          end else if (w_flush) begin
            pend_addr_q <= w_target;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  cv32e40p_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (w_flush),
    .push_i  (w_push),
    .wdata_i ({instr_rdata_i, instr_err_i}),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_head),
    .empty_o (w_fifo_empty),
    .full_o  (w_fifo_full),
    .cnt_o   (w_fifo_cnt)
  );

  // Consumer side: FIFO head first, else same-cycle response; silent on flush
  always_comb begin
    fetch_valid_o = 1'b0;
    fetch_rdata_o = '0;
    fetch_err_o   = 1'b0;
    if (!w_flush) begin
      if (!w_fifo_empty) begin
        fetch_valid_o = 1'b1;
        fetch_rdata_o = w_fifo_head[ENT_W-1:1];
        fetch_err_o   = w_fifo_head[0];
      end else if (w_keep) begin
        fetch_valid_o = 1'b1;
        fetch_rdata_o = instr_rdata_i;
        fetch_err_o   = instr_err_i;
      end
    end
  end

  assign instr_req_o  = (state_q != IDLE);
  assign instr_addr_o = addr_q;
  assign fifo_cnt_o   = w_fifo_cnt;
  assign busy_o       = instr_req_o | (out_cnt_q != '0);

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_i |-> (out_cnt_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (!w_fifo_full || w_pop));

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_prefetch_buffer_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_prefetch_buffer_n
// Purpose  : Self-checking bench: OBI memory model plus word scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40p_prefetch_buffer_n;
  import cv32e40p_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, branch_i, hwlp_jump_i, fetch_ready_i;
  logic [31:0] branch_addr_i, hwlp_target_i;
  logic        fetch_valid_o, fetch_err_o;
  logic [31:0] fetch_rdata_o;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic [2:0]  fifo_cnt_o;
  logic        busy_o;

  cv32e40p_prefetch_buffer_n dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .hwlp_jump_i    (hwlp_jump_i),
    .hwlp_target_i  (hwlp_target_i),
    .fetch_ready_i  (fetch_ready_i),
    .fetch_valid_o  (fetch_valid_o),
    .fetch_rdata_o  (fetch_rdata_o),
    .fetch_err_o    (fetch_err_o),
    .instr_req_o    (instr_req_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_addr_o   (instr_addr_o),
    .instr_rdata_i  (instr_rdata_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_err_i    (instr_err_i),
    .fifo_cnt_o     (fifo_cnt_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          deliver;
  } resp_t;

  int           checks   = 0;
  int           failures = 0;
  int           n_deliv  = 0;
  resp_t        resp_q[$];
  fetch_entry_t exp_q[$];
  logic [31:0]  gnt_log[$];
  fetch_entry_t deliv_log[$];

  bit          gnt_en     = 1'b1;
  bit          hold_rsp   = 1'b0;
  logic [31:0] err_addr   = 32'h1;
  logic [31:0] exp_addr   = 32'h0;
  bit          junk_pend  = 1'b0;
  bit          prev_ungnt = 1'b0;
  logic [31:0] held_addr  = 32'h0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] gnt_at(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic fetch_entry_t deliv_at(input int i);
    if (i < deliv_log.size()) return deliv_log[i];
    return 'x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory drives at negedge, outputs checked, then posedge passes
  task automatic run_cycle();
    resp_t        r;
    fetch_entry_t e;
    bit           have_rsp, flush;
    @(negedge clk);
    instr_gnt_i = gnt_en;
    have_rsp = !hold_rsp && (resp_q.size() != 0);
    if (have_rsp) begin
      r = resp_q[0];
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = data_of(r.addr);
      instr_err_i    = (r.addr == err_addr);
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'h0;
      instr_err_i    = 1'b0;
    end
    #1;
    flush = branch_i || hwlp_jump_i;
    check("fifo_cnt", fifo_cnt_o, exp_q.size());
    check("busy", busy_o, (instr_req_o || resp_q.size() != 0));
    if (prev_ungnt) begin
      check("req_held", instr_req_o, 1'b1);
      check("addr_held", instr_addr_o, held_addr);
    end
    if (have_rsp) begin
      void'(resp_q.pop_front());
      if (r.deliver && !flush) begin
        e.data = data_of(r.addr);
        e.err  = (r.addr == err_addr);
        exp_q.push_back(e);
      end
    end
    if (flush) exp_q.delete();
    check("valid", fetch_valid_o, (exp_q.size() != 0));
    if (fetch_valid_o && fetch_ready_i && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rdata", fetch_rdata_o, e.data);
      check("err", fetch_err_o, e.err);
      deliv_log.push_back('{data: fetch_rdata_o, err: fetch_err_o});
      n_deliv++;
    end
    if (instr_req_o && instr_gnt_i) begin
      r.addr = instr_addr_o;
      if (junk_pend) begin
        r.deliver = 1'b0;
        junk_pend = 1'b0;
      end else begin
        check("gnt_addr", instr_addr_o, exp_addr);
        exp_addr  = exp_addr + 32'd4;
        r.deliver = !flush;
      end
      resp_q.push_back(r);
      gnt_log.push_back(instr_addr_o);
    end
    if (flush) begin
      foreach (resp_q[i]) resp_q[i].deliver = 1'b0;
      if (instr_req_o && !instr_gnt_i) junk_pend = 1'b1;
      exp_addr = (branch_i ? branch_addr_i : hwlp_target_i) & 32'hFFFF_FFFC;
    end
    prev_ungnt = instr_req_o && !instr_gnt_i;
    held_addr  = instr_addr_o;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_i = 1'b0; fetch_ready_i = 1'b1; hold_rsp = 1'b0; gnt_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      run_cycle();
      if (!busy_o && fifo_cnt_o == 3'd0 && resp_q.size() == 0) break;
    end
    check("drain_idle", {busy_o, fifo_cnt_o}, 4'h0);
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    deliv_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap, n_err;
    rst_n = 1'b0; req_i = 1'b0; branch_i = 1'b0; hwlp_jump_i = 1'b0;
    branch_addr_i = 32'h0; hwlp_target_i = 32'h0; fetch_ready_i = 1'b0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; instr_err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {fetch_valid_o, fetch_err_o, instr_req_o, busy_o, fifo_cnt_o}, 7'h0);
    check("rst_rdata", fetch_rdata_o, 32'h0);
    check("rst_addr", instr_addr_o, 32'h0);
    rst_n = 1'b1;

    // Branch to 0x100, stream one word per cycle
    clear_logs();
    req_i = 1'b1; fetch_ready_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h100;
    run_cycle();
    branch_i = 1'b0;
    run_cycle();
    snap = n_deliv;
    repeat (6) run_cycle();
    check("throughput", n_deliv - snap, 6);
    check("seq_0", gnt_at(0), 32'h100);
    check("seq_1", gnt_at(1), 32'h104);
    check("seq_2", gnt_at(2), 32'h108);

    // Backpressure: fill the FIFO and stop requesting
    fetch_ready_i = 1'b0;
    repeat (10) run_cycle();
    check("full_cnt", fifo_cnt_o, 3'd4);
    check("full_noreq", instr_req_o, 1'b0);
    fetch_ready_i = 1'b1;
    repeat (4) run_cycle();
    drain();

    // Two outstanding, branch to 0x200 before either response
    hold_rsp = 1'b1; req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      if (resp_q.size() == 2) break;
    end
    check("two_outstanding", resp_q.size(), 2);
    clear_logs();
    branch_i = 1'b1; branch_addr_i = 32'h200;
    run_cycle();
    branch_i = 1'b0; hold_rsp = 1'b0;
    repeat (8) run_cycle();
    check("drop_first", deliv_at(0), {data_of(32'h200), 1'b0});
    drain();

    // Branch while ungranted at 0x40, new target 0x80
    gnt_en = 1'b0; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h40;
    run_cycle();
    branch_i = 1'b0;
    run_cycle();
    branch_i = 1'b1; branch_addr_i = 32'h80;
    run_cycle();
    branch_i = 1'b0;
    repeat (2) run_cycle();
    check("ungnt_addr", instr_addr_o, 32'h40);
    check("ungnt_req", instr_req_o, 1'b1);
    clear_logs();
    gnt_en = 1'b1;
    repeat (6) run_cycle();
    check("ungnt_gnt0", gnt_at(0), 32'h40);
    check("ungnt_gnt1", gnt_at(1), 32'h80);
    check("ungnt_first", deliv_at(0), {data_of(32'h80), 1'b0});
    drain();

    // Bus error on the word from 0x10 only
    err_addr = 32'h10; clear_logs();
    req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h8;
    run_cycle();
    branch_i = 1'b0;
    repeat (8) run_cycle();
    n_err = 0;
    foreach (deliv_log[i]) if (deliv_log[i].err) n_err++;
    check("err_count", n_err, 1);
    check("err_word", deliv_at(2), {data_of(32'h10), 1'b1});
    err_addr = 32'h1;

    // Simultaneous branch and hwloop jump mid-stream: branch wins
    branch_i = 1'b1; branch_addr_i = 32'h300; hwlp_jump_i = 1'b1; hwlp_target_i = 32'h400;
    run_cycle();
    branch_i = 1'b0; hwlp_jump_i = 1'b0; clear_logs();
    repeat (5) run_cycle();
    check("prio_gnt0", gnt_at(0), 32'h300);
    check("prio_gnt1", gnt_at(1), 32'h304);
    check("prio_first", deliv_at(0), {data_of(32'h300), 1'b0});

    // Hardware-loop jump alone, low address bits ignored
    hwlp_jump_i = 1'b1; hwlp_target_i = 32'h502;
    run_cycle();
    hwlp_jump_i = 1'b0; clear_logs();
    repeat (5) run_cycle();
    check("hwlp_gnt0", gnt_at(0), 32'h500);
    check("hwlp_first", deliv_at(0), {data_of(32'h500), 1'b0});

    // Address wraps at the top of the address space
    branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFB;
    run_cycle();
    branch_i = 1'b0; clear_logs();
    repeat (6) run_cycle();
    check("wrap_0", gnt_at(0), 32'hFFFF_FFF8);
    check("wrap_1", gnt_at(1), 32'hFFFF_FFFC);
    check("wrap_2", gnt_at(2), 32'h0000_0000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
